// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Serial receive front end: turns the asynchronous 8N1 rs232_rx line into one
//   parallel byte per valid frame, with a one-cycle valid strobe. Flags framing
//   errors (stop bit low) and rejects short low glitches on the start bit.
//
// Parameters
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          line rate in bit/s
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rs232_rx      serial line, idle high, asynchronous to clk
//   rx_data       last correctly received byte (LSB first on the line)
//   rx_valid      one-cycle pulse: rx_data updated this cycle
//   rx_frame_err  one-cycle pulse: stop bit sampled low
//   rx_busy       high from start-edge detect until return to IDLE
module uart_rx_deframer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CW       = $clog2(BAUD_CNT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [2:0]    sync_vld;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          fall;

    // The sync FFs come out of reset high, which would fake a 1->0 edge if the
    // line is held low across reset. sync_vld marks which stages hold a real
    // line sample; an edge only counts once s3 is a genuine high sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            sync_vld <= '0;
        end else begin
            s1       <= rs232_rx;
            s2       <= s1;
            s3       <= s2;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign fall = sync_vld[2] & s3 & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (fall) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                // Half a bit in: a line back high means a glitch, not a start bit.
                // Otherwise restart the counter so later samples land mid-bit.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (s2) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= s2;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (s2) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Line stuck low after a bad stop bit: no new frame until it is high.
                BREAK: begin
                    cnt <= '0;
                    if (s2) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
// Bench for uart_rx_deframer. Runs with 32 clocks per bit to keep frames short.
// The driver puts expected outcomes into exp_q when it starts a frame; a
// separate monitor pops and compares whenever the DUT pulses an output.
module tb_uart_rx_deframer;

    localparam int  BAUD     = 100_000;
    localparam int  CLK_FREQ = 3_200_000;
    localparam int  BCNT     = CLK_FREQ / BAUD;
    localparam int  HCNT     = BCNT / 2;
    localparam real BIT_NS   = 10.0 * BCNT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;

    uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         valid_cyc[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (rx_valid || rx_frame_err)) begin
            chk("valid_err_exclusive", {31'b0, rx_valid & rx_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'b0, rx_valid, rx_frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_is_err", {31'b0, rx_frame_err}, {31'b0, e.err});
                chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
            end
            if (rx_valid) valid_cyc.push_back(cyc);
        end
    end

    // Drive one frame. A bad stop bit keeps the line low one more bit, then idles
    // high for a bit so the receiver leaves its break wait.
    task automatic send_frame(input logic [7:0] d, input bit good_stop,
                              input real bit_ns, input bit expect_out);
        if (expect_out) begin
            if (good_stop) begin
                exp_q.push_back({1'b0, d});
                model_data = d;
            end else begin
                exp_q.push_back({1'b1, model_data});
            end
        end
        rs232_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            #(bit_ns);
        end
        rs232_rx = good_stop;
        #(bit_ns);
        if (!good_stop) begin
            #(bit_ns);
            rs232_rx = 1'b1;
            #(bit_ns);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
        chk({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'd0);
        chk({tag, "_rx_frame_err"}, {31'b0, rx_frame_err}, 32'd0);
        chk({tag, "_rx_busy"}, {31'b0, rx_busy}, 32'd0);
    endtask

    initial begin
        int diff;
        logic [7:0] d;
        bit good;
        real bn;

        // Reset state
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame 0x55, busy low after the stop bit
        send_frame(8'h55, 1'b1, BIT_NS, 1'b1);
        @(negedge clk);
        chk("busy_after_frame", {31'b0, rx_busy}, 32'd0);
        drain(4 * BCNT);

        // Back-to-back frames, no idle gap
        valid_cyc.delete();
        send_frame(8'hA3, 1'b1, BIT_NS, 1'b1);
        send_frame(8'h0F, 1'b1, BIT_NS, 1'b1);
        drain(4 * BCNT);
        if (valid_cyc.size() >= 2) begin
            diff = valid_cyc[1] - valid_cyc[0];
            chk("b2b_spacing", diff, 10 * BCNT);
        end else begin
            chk("b2b_pulse_count", valid_cyc.size(), 32'd2);
        end
        repeat (BCNT) @(negedge clk);

        // Short glitch on idle line: busy for about half a bit, nothing emitted
        rs232_rx = 1'b0;
        #40;
        rs232_rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_busy_high", {31'b0, rx_busy}, 32'd1);
        repeat (HCNT + 8) @(negedge clk);
        chk("glitch_busy_low", {31'b0, rx_busy}, 32'd0);
        repeat (2 * BCNT) @(negedge clk);
        chk("glitch_data_held", {24'b0, rx_data}, {24'b0, model_data});

        // Framing error, then a clean frame
        send_frame(8'h3C, 1'b0, BIT_NS, 1'b1);
        drain(4 * BCNT);
        chk("ferr_busy_low", {31'b0, rx_busy}, 32'd0);
        send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
        drain(4 * BCNT);
        repeat (BCNT) @(negedge clk);

        // Reset during bit 4 of 0xC6 (bits 4,5 low, 6,7 and stop high: no
        // further falling edge, so nothing may start after release)
        d = 8'hC6;
        rs232_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = d[i];
            #(BIT_NS);
        end
        rs232_rx = d[4];
        #(BIT_NS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midframe_reset");
        rst_n = 1'b1;
        model_data = 8'h00;
        repeat (BCNT) @(negedge clk);
        chk("low_line_no_start", {31'b0, rx_busy}, 32'd0);
        for (int i = 6; i < 8; i++) begin
            rs232_rx = d[i];
            #(BIT_NS);
        end
        rs232_rx = 1'b1;
        #(2 * BIT_NS);
        chk("post_reset_data", {24'b0, rx_data}, 32'd0);
        send_frame(8'hC6, 1'b1, BIT_NS, 1'b1);
        drain(4 * BCNT);

        // Baud tolerance +/-2%
        send_frame(8'hE7, 1'b1, BIT_NS * 0.98, 1'b1);
        drain(4 * BCNT);
        send_frame(8'hE7, 1'b1, BIT_NS * 1.02, 1'b1);
        drain(4 * BCNT);

        // Random frames: random byte, occasional bad stop, +/-2% rate, random gap
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
            bn   = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            send_frame(d, good, bn, 1'b1);
            #(BIT_NS * real'($urandom_range(0, 3)));
        end
        drain(4 * BCNT);
        repeat (BCNT) @(negedge clk);
        chk("final_busy_low", {31'b0, rx_busy}, 32'd0);
        chk("final_data_held", {24'b0, rx_data}, {24'b0, model_data});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
